// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch
// Description : PC register, req/ack instruction fetch and next-PC selection
//               feeding the Extend stage.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  pc_op,
    input  logic        branch_taken,
    input  logic [31:0] ext_imm,
    input  logic [31:0] jr_target,
    input  logic        advance,
    input  logic        halt,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [15:0] immediate,
    output logic        halted
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_FETCH = 2'd1;
    localparam logic [1:0] c_VALID = 2'd2;
    localparam logic [1:0] c_HALT  = 2'd3;

    localparam logic [1:0] c_OP_SEQ    = 2'b00;
    localparam logic [1:0] c_OP_BRANCH = 2'b01;
    localparam logic [1:0] c_OP_JUMP   = 2'b10;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        armed_q, armed_d;
    logic [31:0] w_next_pc;

    assign pc          = pc_q;
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign pc_plus4    = pc_q + 32'd4;
    assign immediate   = instr_q[15:0];
    assign imem_req    = (state_q == c_FETCH);
    assign instr_valid = (state_q == c_VALID);
    assign halted      = (state_q == c_HALT);

    always_comb begin
        w_next_pc = pc_plus4;
        case (pc_op)
            c_OP_SEQ:    w_next_pc = pc_plus4;
            c_OP_BRANCH: w_next_pc = branch_taken ? (pc_plus4 + (ext_imm << 2)) : pc_plus4;
            c_OP_JUMP:   w_next_pc = {pc_plus4[31:28], instr_q[25:0], 2'b00};
            default:     w_next_pc = jr_target & ~32'h0000_0003;
        endcase
    end

    // The first edge after reset release only arms the stage, so IDLE spans
    // one full cycle and the first request rises on the second edge.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        armed_d = 1'b1;
        case (state_q)
            c_IDLE: begin
                if (armed_q) begin
                    state_d = c_FETCH;
                end
            end
            c_FETCH: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = c_VALID;
                end
            end
            c_VALID: begin
                if (halt) begin
                    state_d = c_HALT;
                end else if (advance) begin
                    pc_d    = w_next_pc;
                    state_d = c_FETCH;
                end
            end
            default: state_d = c_HALT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= c_IDLE;
            pc_q    <= RESET_PC;
            instr_q <= 32'd0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            armed_q <= armed_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch
// Description : Directed and randomized bench for instr_fetch with a
//               transaction-level PC model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  pc_op = 2'b00;
    logic        branch_taken = 1'b0;
    logic [31:0] ext_imm = 32'd0;
    logic [31:0] jr_target = 32'd0;
    logic        advance = 1'b0;
    logic        halt = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [15:0] immediate;
    logic        halted;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [31:0] exp_pc;
    logic [31:0] exp_instr;

    instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset(reset), .pc_op(pc_op), .branch_taken(branch_taken),
        .ext_imm(ext_imm), .jr_target(jr_target), .advance(advance), .halt(halt),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .instr(instr), .instr_valid(instr_valid),
        .pc(pc), .pc_plus4(pc_plus4), .immediate(immediate), .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total_cnt++;
        assert (obs === expv) pass_cnt++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Reference next-PC, written straight from the architectural rules.
    function automatic logic [31:0] model_next(input logic [31:0] cur, input logic [31:0] cur_instr,
                                               input logic [1:0] op, input logic tk,
                                               input logic [31:0] imm, input logic [31:0] tgt);
        logic [31:0] seq;
        seq = cur + 32'd4;
        if (op == 2'd0)      return seq;
        else if (op == 2'd1) return tk ? seq + imm * 32'd4 : seq;
        else if (op == 2'd2) return (seq & 32'hF000_0000) | ((cur_instr & 32'h03FF_FFFF) * 32'd4);
        else                 return tgt - (tgt % 32'd4);
    endfunction

    task automatic check_reset_values(input string tag);
        chk({tag, "_req"},   {31'd0, imem_req}, 32'd0);
        chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
        chk({tag, "_halted"},{31'd0, halted}, 32'd0);
        chk({tag, "_pc"},    pc, 32'h0000_0000);
        chk({tag, "_instr"}, instr, 32'd0);
    endtask

    // Entered at a negedge with the stage in FETCH.
    task automatic fetch_one(input logic [31:0] word, input int waits);
        chk("fetch_req", {31'd0, imem_req}, 32'd1);
        chk("fetch_addr", imem_addr, exp_pc);
        for (int i = 0; i < waits; i++) begin
            imem_ack = 1'b0;
            tick();
            chk("wait_addr_stable", imem_addr, exp_pc);
            chk("wait_no_valid", {31'd0, instr_valid}, 32'd0);
        end
        imem_ack = 1'b1;
        imem_rdata = word;
        tick();
        imem_ack = 1'b0;
        imem_rdata = $urandom;
        exp_instr = word;
        chk("valid_after_ack", {31'd0, instr_valid}, 32'd1);
        chk("valid_req_low", {31'd0, imem_req}, 32'd0);
        chk("instr", instr, exp_instr);
        chk("immediate", {16'd0, immediate}, {16'd0, word[15:0]});
        chk("pc_plus4", pc_plus4, exp_pc + 32'd4);
    endtask

    // Entered at a negedge with the stage in VALID.
    task automatic advance_op(input logic [1:0] op, input logic tk,
                              input logic [31:0] imm, input logic [31:0] tgt);
        pc_op = op;
        branch_taken = tk;
        ext_imm = imm;
        jr_target = tgt;
        advance = 1'b1;
        tick();
        advance = 1'b0;
        exp_pc = model_next(exp_pc, exp_instr, op, tk, imm, tgt);
        chk("adv_valid_low", {31'd0, instr_valid}, 32'd0);
        chk("adv_req_high", {31'd0, imem_req}, 32'd1);
        chk("adv_new_pc", pc, exp_pc);
    endtask

    initial begin
        int waits;
        int holds;
        logic [31:0] word;
        exp_pc = 32'h0000_0000;
        exp_instr = 32'd0;

        // Reset and first request timing
        tick();
        check_reset_values("reset");
        reset = 1'b0;
        tick();
        chk("idle_edge1_req", {31'd0, imem_req}, 32'd0);
        tick();
        chk("idle_edge2_req", {31'd0, imem_req}, 32'd1);

        // Sequential zero-wait fetch
        fetch_one(32'h2001_0005, 0);
        chk("seq_imm", {16'd0, immediate}, 32'h0000_0005);
        advance_op(2'b00, 1'b0, 32'd0, 32'd0);
        chk("seq_addr4", imem_addr, 32'h0000_0004);
        fetch_one(32'h2001_0005, 0);
        advance_op(2'b00, 1'b0, 32'd0, 32'd0);
        chk("seq_addr8", imem_addr, 32'h0000_0008);
        fetch_one(32'h2001_0005, 0);

        // Backward branch taken / not taken from 0x100
        advance_op(2'b11, 1'b0, 32'd0, 32'h0000_0101);
        chk("jr_to_100", imem_addr, 32'h0000_0100);
        fetch_one($urandom, 0);
        advance_op(2'b01, 1'b1, 32'hFFFF_FFFE, 32'd0);
        chk("branch_back", imem_addr, 32'h0000_00FC);
        fetch_one($urandom, 1);
        advance_op(2'b11, 1'b0, 32'd0, 32'h0000_0100);
        fetch_one($urandom, 0);
        advance_op(2'b01, 1'b0, 32'hFFFF_FFFE, 32'd0);
        chk("branch_not_taken", imem_addr, 32'h0000_0104);
        fetch_one($urandom, 0);

        // Jump and jr
        advance_op(2'b11, 1'b0, 32'd0, 32'hF000_0010);
        fetch_one(32'h0800_0040, 2);
        advance_op(2'b10, 1'b0, 32'd0, 32'd0);
        chk("jump_target", imem_addr, 32'hF000_0100);
        fetch_one($urandom, 0);
        advance_op(2'b11, 1'b0, 32'd0, 32'h0000_0123);
        chk("jr_aligned", imem_addr, 32'h0000_0120);

        // Wait states
        fetch_one($urandom, 3);

        // Wrap-around
        advance_op(2'b11, 1'b0, 32'd0, 32'hFFFF_FFFC);
        fetch_one($urandom, 0);
        advance_op(2'b00, 1'b0, 32'd0, 32'd0);
        chk("wrap_addr", imem_addr, 32'h0000_0000);

        // Randomized traffic against the model
        for (int n = 0; n < 40; n++) begin
            waits = $urandom_range(0, 3);
            word = $urandom;
            fetch_one(word, waits);
            holds = $urandom_range(0, 2);
            for (int h = 0; h < holds; h++) begin
                tick();
                chk("hold_valid", {31'd0, instr_valid}, 32'd1);
                chk("hold_pc", pc, exp_pc);
            end
            advance_op(2'($urandom_range(0, 3)), 1'($urandom), $urandom, $urandom);
        end
        fetch_one($urandom, 1);

        // Halt has priority over advance
        halt = 1'b1;
        advance = 1'b1;
        pc_op = 2'b01;
        branch_taken = 1'b1;
        ext_imm = 32'd8;
        tick();
        chk("halt_halted", {31'd0, halted}, 32'd1);
        chk("halt_pc", pc, exp_pc);
        chk("halt_instr", instr, exp_instr);
        chk("halt_valid", {31'd0, instr_valid}, 32'd0);
        chk("halt_req", {31'd0, imem_req}, 32'd0);
        halt = 1'b0;
        for (int h = 0; h < 3; h++) begin
            tick();
            chk("halt_sticky", {31'd0, halted}, 32'd1);
            chk("halt_pc_hold", pc, exp_pc);
        end
        advance = 1'b0;

        // Reset mid-halt aborts asynchronously
        #2 reset = 1'b1;
        #1 check_reset_values("reset_mid_halt");
        tick();
        reset = 1'b0;
        exp_pc = 32'h0000_0000;
        tick();
        tick();
        chk("restart_req", {31'd0, imem_req}, 32'd1);

        // Reset mid-fetch with ack pending; late ack ignored in IDLE
        imem_ack = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        #2 reset = 1'b1;
        #1 check_reset_values("reset_mid_fetch");
        tick();
        reset = 1'b0;
        tick();
        chk("late_ack_valid", {31'd0, instr_valid}, 32'd0);
        chk("late_ack_instr", instr, 32'd0);
        imem_ack = 1'b0;
        tick();
        chk("post_reset_req", {31'd0, imem_req}, 32'd1);
        fetch_one(32'h1234_5678, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
